psram_qpi_ctrl: RTL and testbench

Parametrised QPI PSRAM controller that owns the full device life cycle: power-up delay, SPI reset/enter-QPI sequence, then single-burst QPI reads and writes of configurable width. It replaces the button-started initialiser plus level-switch command driver with a valid/ready request port and a one-cycle response strobe. It sits between user logic (UART bridge, test sequencers) and the PSRAM pins, with the tristate buffer split out to the top level.

---
 rtl/psram_qpi_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_psram_qpi_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psram_qpi_ctrl
// Brief    : QPI PSRAM controller: power-up delay, SPI reset/enter-QPI, then
//            single-burst QPI reads/writes behind a valid/ready request port.
//            Define PSRAM_AUTO_INIT_EN to start initialisation right after reset.
// Revision : 1.0 - initial release
// ============================================================================
module psram_qpi_ctrl #(
    parameter int DATA_W      = 16,
    parameter int INIT_CYCLES = 12800,
    parameter int READ_WAIT   = 6
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [23:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_ce,
    output logic [3:0]        mem_sio_o,
    output logic [3:0]        mem_sio_oe,
    input  logic [3:0]        mem_sio_i
);

    localparam int c_nibbles = DATA_W / 4;
    localparam int c_dly_w   = $clog2(INIT_CYCLES + 1);
    localparam int c_ph_max  = (READ_WAIT > 8) ?
                               ((READ_WAIT > c_nibbles) ? READ_WAIT : c_nibbles) :
                               ((c_nibbles > 8) ? c_nibbles : 8);
    localparam int c_ph_w    = $clog2(c_ph_max + 1);

    localparam logic [c_dly_w-1:0] c_dly_last  = c_dly_w'(INIT_CYCLES - 1);
    localparam logic [c_ph_w-1:0]  c_spi_last  = c_ph_w'(7);
    localparam logic [c_ph_w-1:0]  c_cmd_last  = c_ph_w'(1);
    localparam logic [c_ph_w-1:0]  c_addr_last = c_ph_w'(5);
    localparam logic [c_ph_w-1:0]  c_wait_last = c_ph_w'(READ_WAIT - 1);
    localparam logic [c_ph_w-1:0]  c_nib_last  = c_ph_w'(c_nibbles - 1);

    localparam logic [7:0] c_qpi_write = 8'h38;
    localparam logic [7:0] c_qpi_read  = 8'hEB;

    typedef enum logic [3:0] {
        S_WAIT_START = 4'd0,
        S_DELAY      = 4'd1,
        S_SPI_CMD    = 4'd2,
        S_SPI_GAP    = 4'd3,
        S_IDLE       = 4'd4,
        S_Q_CMD      = 4'd5,
        S_Q_ADDR     = 4'd6,
        S_Q_WAIT     = 4'd7,
        S_Q_DATA     = 4'd8,
        S_Q_GAP      = 4'd9
    } state_t;

    // Reset-enable, reset, enter-QPI, sent in that order over single-bit SPI.
    function automatic logic [7:0] spi_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    spi_cmd = 8'h66;
            2'd1:    spi_cmd = 8'h99;
            default: spi_cmd = 8'h35;
        endcase
    endfunction

    state_t              r_state;
    logic [c_dly_w-1:0]  r_dly_cnt;
    logic [c_ph_w-1:0]   r_ph_cnt;
    logic [1:0]          r_spi_idx;
    logic [7:0]          r_spi_sr;
    logic [27:0]         r_tx_sr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wd_sr;
    logic [DATA_W-1:0]   r_rd_sr;

    logic                w_start;
    logic [7:0]          w_spi_first;
    logic [7:0]          w_spi_next;
    logic [3:0]          w_wd_top;
    logic [DATA_W-1:0]   w_rd_next;

`ifdef PSRAM_AUTO_INIT_EN
    logic w_unused_init_start;
    assign w_unused_init_start = init_start;
    assign w_start             = 1'b1;
`else
    assign w_start = init_start;
`endif

    assign w_spi_first = spi_cmd(2'd0);
    assign w_spi_next  = spi_cmd(r_spi_idx + 2'd1);
    assign w_wd_top    = r_wd_sr[DATA_W-1 -: 4];
    assign w_rd_next   = (r_rd_sr << 4) | DATA_W'(mem_sio_i);

    // All pad and handshake outputs are registered; each branch loads the
    // values the next cycle must present.
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT_START;
            r_dly_cnt  <= '0;
            r_ph_cnt   <= '0;
            r_spi_idx  <= '0;
            r_spi_sr   <= '0;
            r_tx_sr    <= '0;
            r_we       <= 1'b0;
            r_wd_sr    <= '0;
            r_rd_sr    <= '0;
            init_done  <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            mem_ce     <= 1'b1;
            mem_sio_o  <= 4'h0;
            mem_sio_oe <= 4'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_WAIT_START: begin
                    if (w_start) begin
                        r_state   <= S_DELAY;
                        r_dly_cnt <= '0;
                    end
                end
                S_DELAY: begin
                    if (r_dly_cnt == c_dly_last) begin
                        r_state    <= S_SPI_CMD;
                        r_spi_idx  <= 2'd0;
                        r_ph_cnt   <= '0;
                        mem_ce     <= 1'b0;
                        mem_sio_oe <= 4'b0001;
                        mem_sio_o  <= {3'b000, w_spi_first[7]};
                        r_spi_sr   <= {w_spi_first[6:0], 1'b0};
                    end else begin
                        r_dly_cnt <= r_dly_cnt + 1'b1;
                    end
                end
                S_SPI_CMD: begin
                    if (r_ph_cnt == c_spi_last) begin
                        r_state    <= S_SPI_GAP;
                        mem_ce     <= 1'b1;
                        mem_sio_oe <= 4'h0;
                        mem_sio_o  <= 4'h0;
                    end else begin
                        r_ph_cnt  <= r_ph_cnt + 1'b1;
                        mem_sio_o <= {3'b000, r_spi_sr[7]};
                        r_spi_sr  <= {r_spi_sr[6:0], 1'b0};
                    end
                end
                S_SPI_GAP: begin
                    if (r_spi_idx == 2'd2) begin
                        r_state   <= S_IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end else begin
                        r_state    <= S_SPI_CMD;
                        r_spi_idx  <= r_spi_idx + 2'd1;
                        r_ph_cnt   <= '0;
                        mem_ce     <= 1'b0;
                        mem_sio_oe <= 4'b0001;
                        mem_sio_o  <= {3'b000, w_spi_next[7]};
                        r_spi_sr   <= {w_spi_next[6:0], 1'b0};
                    end
                end
                S_IDLE: begin
                    if (req_valid) begin
                        r_state    <= S_Q_CMD;
                        req_ready  <= 1'b0;
                        r_we       <= req_we;
                        r_wd_sr    <= req_wdata;
                        r_ph_cnt   <= '0;
                        mem_ce     <= 1'b0;
                        mem_sio_oe <= 4'hF;
                        mem_sio_o  <= req_we ? c_qpi_write[7:4] : c_qpi_read[7:4];
                        r_tx_sr    <= {(req_we ? c_qpi_write[3:0] : c_qpi_read[3:0]), req_addr};
                    end
                end
                S_Q_CMD: begin
                    mem_sio_o <= r_tx_sr[27:24];
                    r_tx_sr   <= r_tx_sr << 4;
                    if (r_ph_cnt == c_cmd_last) begin
                        r_state  <= S_Q_ADDR;
                        r_ph_cnt <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_Q_ADDR: begin
                    if (r_ph_cnt == c_addr_last) begin
                        r_ph_cnt <= '0;
                        if (r_we) begin
                            r_state   <= S_Q_DATA;
                            mem_sio_o <= w_wd_top;
                            r_wd_sr   <= r_wd_sr << 4;
                        end else begin
                            r_state    <= (READ_WAIT == 0) ? S_Q_DATA : S_Q_WAIT;
                            mem_sio_oe <= 4'h0;
                            mem_sio_o  <= 4'h0;
                        end
                    end else begin
                        r_ph_cnt  <= r_ph_cnt + 1'b1;
                        mem_sio_o <= r_tx_sr[27:24];
                        r_tx_sr   <= r_tx_sr << 4;
                    end
                end
                S_Q_WAIT: begin
                    if (r_ph_cnt == c_wait_last) begin
                        r_state  <= S_Q_DATA;
                        r_ph_cnt <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + 1'b1;
                    end
                end
                S_Q_DATA: begin
                    if (r_we) begin
                        if (r_ph_cnt == c_nib_last) begin
                            r_state    <= S_Q_GAP;
                            mem_ce     <= 1'b1;
                            mem_sio_oe <= 4'h0;
                            mem_sio_o  <= 4'h0;
                        end else begin
                            r_ph_cnt  <= r_ph_cnt + 1'b1;
                            mem_sio_o <= w_wd_top;
                            r_wd_sr   <= r_wd_sr << 4;
                        end
                    end else begin
                        // The device launches on the inverted clock, so each
                        // nibble is stable by this block's rising edge.
                        r_rd_sr <= w_rd_next;
                        if (r_ph_cnt == c_nib_last) begin
                            r_state   <= S_Q_GAP;
                            mem_ce    <= 1'b1;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= w_rd_next;
                        end else begin
                            r_ph_cnt <= r_ph_cnt + 1'b1;
                        end
                    end
                end
                S_Q_GAP: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state    <= S_WAIT_START;
                    mem_ce     <= 1'b1;
                    mem_sio_oe <= 4'h0;
                    mem_sio_o  <= 4'h0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_qpi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_qpi_ctrl
// Brief    : Directed self-checking bench for psram_qpi_ctrl (16-bit and 32-bit
//            instances sharing clock/reset). Honours PSRAM_AUTO_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psram_qpi_ctrl;

    localparam int INIT_CYCLES = 100;
    localparam int READ_WAIT   = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic init_start;

    logic        a_init_done, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_ce;
    logic [23:0] a_req_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata, a_rd_data;
    logic [3:0]  a_sio_o, a_sio_oe, a_sio_i;

    logic        b_init_done, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_ce;
    logic [23:0] b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata, b_rd_data;
    logic [3:0]  b_sio_o, b_sio_oe, b_sio_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    psram_qpi_ctrl #(.DATA_W(16), .INIT_CYCLES(INIT_CYCLES), .READ_WAIT(READ_WAIT)) u_dut_a (
        .mem_clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(a_init_done),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .mem_ce(a_ce), .mem_sio_o(a_sio_o),
        .mem_sio_oe(a_sio_oe), .mem_sio_i(a_sio_i));

    psram_qpi_ctrl #(.DATA_W(32), .INIT_CYCLES(INIT_CYCLES), .READ_WAIT(READ_WAIT)) u_dut_b (
        .mem_clk(clk), .rst_n(rst_n), .init_start(init_start), .init_done(b_init_done),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .mem_ce(b_ce), .mem_sio_o(b_sio_o),
        .mem_sio_oe(b_sio_oe), .mem_sio_i(b_sio_i));

    // Device A: returns a_rd_data during the 4 data cycles after 8+READ_WAIT.
    int a_cyc = 0;
    always @(negedge clk) begin
        if (a_ce) begin
            a_cyc   = 0;
            a_sio_i = 4'h0;
        end else begin
            if (a_cyc >= 14 && a_cyc < 18) a_sio_i = a_rd_data[4*(17-a_cyc) +: 4];
            else                            a_sio_i = 4'h0;
            a_cyc++;
        end
    end

    // Device B: small memory decoded from the observed QPI nibble stream.
    int          b_cyc = 0;
    logic [3:0]  b_nibs [$];
    logic [31:0] b_mem [logic [23:0]];
    logic [23:0] b_addr;
    logic [31:0] b_data;
    always @(negedge clk) begin
        if (b_ce) begin
            if (b_nibs.size() == 16 && {b_nibs[0], b_nibs[1]} == 8'h38) begin
                b_addr = {b_nibs[2], b_nibs[3], b_nibs[4], b_nibs[5], b_nibs[6], b_nibs[7]};
                b_data = '0;
                for (int i = 8; i < 16; i++) b_data = {b_data[27:0], b_nibs[i]};
                b_mem[b_addr] = b_data;
            end
            b_nibs.delete();
            b_cyc   = 0;
            b_sio_i = 4'h0;
        end else begin
            if (b_sio_oe == 4'hF) b_nibs.push_back(b_sio_o);
            if (b_cyc == 8 && b_nibs.size() >= 8) begin
                b_addr    = {b_nibs[2], b_nibs[3], b_nibs[4], b_nibs[5], b_nibs[6], b_nibs[7]};
                b_rd_data = b_mem.exists(b_addr) ? b_mem[b_addr] : 32'h0;
            end
            if (b_cyc >= 14 && b_cyc < 22) b_sio_i = b_rd_data[4*(21-b_cyc) +: 4];
            else                            b_sio_i = 4'h0;
            b_cyc++;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; init_start = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rd_data = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rd_data = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (a_ce !== 1'b1)       begin n_fail++; $display("FAIL reset_ce got=%b exp=1", a_ce); end
        n_checks++; if (a_sio_oe !== 4'h0)   begin n_fail++; $display("FAIL reset_oe got=%h exp=0", a_sio_oe); end
        n_checks++; if (a_sio_o !== 4'h0)    begin n_fail++; $display("FAIL reset_sio got=%h exp=0", a_sio_o); end
        n_checks++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", a_req_ready); end
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        n_checks++; if (a_rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", a_rsp_rdata); end
        n_checks++; if (a_init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got=%b exp=0", a_init_done); end
        n_checks++; if (b_ce !== 1'b1)       begin n_fail++; $display("FAIL reset_ce_b got=%b exp=1", b_ce); end
    endtask

    // Without auto-init, releasing reset must leave the pads idle until init_start.
    task automatic test_quiet_after_reset;
`ifndef PSRAM_AUTO_INIT_EN
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if ({a_ce, b_ce, a_init_done, a_sio_oe} !== 7'b1100000) begin
                n_fail++;
                $display("FAIL quiet_after_reset cyc=%0d got={ce_a,ce_b,done,oe}=%b exp=1100000",
                         c, {a_ce, b_ce, a_init_done, a_sio_oe});
            end
        end
`endif
    endtask

    task automatic test_init;
        logic [7:0] cmds [3];
        logic       e_ce, e_bit, e_done;
        logic [3:0] e_oe;
        int         j;
        cmds[0] = 8'h66; cmds[1] = 8'h99; cmds[2] = 8'h35;
`ifdef PSRAM_AUTO_INIT_EN
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
`else
        @(negedge clk) init_start = 1'b1;
        @(posedge clk);
        #1 init_start = 1'b0;
`endif
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            e_ce = 1'b1; e_oe = 4'h0; e_bit = 1'b0; e_done = (c >= 127);
            if (c >= 100 && c < 127) begin
                j = c - 100;
                if (j % 9 < 8) begin
                    e_ce = 1'b0; e_oe = 4'b0001; e_bit = cmds[j/9][7 - (j % 9)];
                end
            end
            n_checks++;
            if ({a_ce, a_sio_oe, a_init_done} !== {e_ce, e_oe, e_done}) begin
                n_fail++;
                $display("FAIL init_pins cyc=%0d got={ce,oe,done}=%b exp=%b", c,
                         {a_ce, a_sio_oe, a_init_done}, {e_ce, e_oe, e_done});
            end
            if (!e_ce) begin
                n_checks++;
                if (a_sio_o[0] !== e_bit) begin
                    n_fail++;
                    $display("FAIL init_spi_bit cyc=%0d got=%b exp=%b", c, a_sio_o[0], e_bit);
                end
            end
        end
        n_checks++; if (b_init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_b got=%b exp=1", b_init_done); end
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready got=%b exp=1", a_req_ready); end
    endtask

    task automatic test_write;
        logic [3:0] exp_nib [12];
        logic [47:0] seq;
        seq = 48'h380000101234;
        for (int i = 0; i < 12; i++) exp_nib[i] = seq[4*(11-i) +: 4];
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 24'h000010; a_req_wdata = 16'h1234;
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_pre got=%b exp=1", a_req_ready); end
        @(posedge clk);
        #1 a_req_valid = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 12) begin
                n_checks++;
                if ({a_ce, a_sio_oe, a_sio_o, a_req_ready} !== {1'b0, 4'hF, exp_nib[c], 1'b0}) begin
                    n_fail++;
                    $display("FAIL wr_nibble cyc=%0d got ce=%b oe=%h sio=%h rdy=%b exp ce=0 oe=F sio=%h rdy=0",
                             c, a_ce, a_sio_oe, a_sio_o, a_req_ready, exp_nib[c]);
                end
            end else begin
                n_checks++;
                if ({a_ce, a_sio_oe, a_req_ready} !== {1'b1, 4'h0, (c == 13)}) begin
                    n_fail++;
                    $display("FAIL wr_tail cyc=%0d got ce=%b oe=%h rdy=%b exp ce=1 oe=0 rdy=%b",
                             c, a_ce, a_sio_oe, a_req_ready, (c == 13));
                end
            end
        end
    endtask

    task automatic test_read;
        logic [31:0] seq;
        int          pulses;
        seq = 32'hEBABCDEF;
        pulses = 0;
        a_rd_data = 16'hA5C3;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 24'hABCDEF;
        @(posedge clk);
        #1 a_req_valid = 1'b0; a_req_addr = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_rsp_valid === 1'b1) pulses++;
            if (c < 8) begin
                n_checks++;
                if ({a_ce, a_sio_oe, a_sio_o} !== {1'b0, 4'hF, seq[4*(7-c) +: 4]}) begin
                    n_fail++;
                    $display("FAIL rd_cmd_addr cyc=%0d got ce=%b oe=%h sio=%h exp ce=0 oe=F sio=%h",
                             c, a_ce, a_sio_oe, a_sio_o, seq[4*(7-c) +: 4]);
                end
            end else if (c < 18) begin
                n_checks++;
                if ({a_ce, a_sio_oe, a_rsp_valid} !== 6'b000000) begin
                    n_fail++;
                    $display("FAIL rd_turnaround cyc=%0d got ce=%b oe=%h rsp=%b exp ce=0 oe=0 rsp=0",
                             c, a_ce, a_sio_oe, a_rsp_valid);
                end
            end else begin
                n_checks++;
                if ({a_ce, a_sio_oe, a_rsp_valid, a_req_ready, a_rsp_rdata} !==
                    {1'b1, 4'h0, (c == 18), (c == 19), 16'hA5C3}) begin
                    n_fail++;
                    $display("FAIL rd_resp cyc=%0d got ce=%b oe=%h rsp=%b rdy=%b data=%h exp ce=1 oe=0 rsp=%b rdy=%b data=a5c3",
                             c, a_ce, a_sio_oe, a_rsp_valid, a_req_ready, a_rsp_rdata, (c == 18), (c == 19));
                end
            end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL rd_pulse_count got=%0d exp=1", pulses); end
    endtask

    task automatic test_back_to_back;
        int t, t0, k, got;
        logic [31:0] data;
        t = 0; t0 = 0; k = 0; got = -1; data = '0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 24'h000100; b_req_wdata = 32'hDEADBEEF;
        while (k < 2 && t < 60) begin
            @(negedge clk);
            t++;
            if (k == 1 && (t - t0 - 1) == 16) begin
                n_checks++;
                if ({b_ce, b_sio_oe} !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL b2b_gap got ce=%b oe=%h exp ce=1 oe=0", b_ce, b_sio_oe);
                end
            end
            if (b_req_ready === 1'b1) begin
                if (k == 0) t0 = t;
                else begin
                    n_checks++;
                    if (t - t0 - 1 !== 17) begin
                        n_fail++;
                        $display("FAIL b2b_spacing got=%0d exp=17", t - t0 - 1);
                    end
                end
                k++;
                @(posedge clk);
                #1;
                if (k == 1) begin b_req_we = 1'b0; b_req_wdata = '0; end
                else        b_req_valid = 1'b0;
            end
        end
        n_checks++; if (k !== 2) begin n_fail++; $display("FAIL b2b_handshakes got=%0d exp=2", k); end
        b_req_valid = 1'b0;
        for (int c = 0; c < 40 && got < 0; c++) begin
            @(negedge clk);
            if (b_rsp_valid === 1'b1) begin got = c; data = b_rsp_rdata; end
        end
        n_checks++; if (got !== 22) begin n_fail++; $display("FAIL b2b_rsp_cycle got=%0d exp=22", got); end
        n_checks++; if (data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_readback got=%h exp=deadbeef", data); end
    endtask

    task automatic test_reset_mid_read;
        a_rd_data = 16'h0F0F;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 24'h000020;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        for (int c = 0; c <= 10; c++) @(negedge clk);
        n_checks++; if (a_ce !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_ce got=%b exp=0", a_ce); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_ce, a_sio_oe, a_init_done, a_req_ready, b_init_done} !== 8'b10000000) begin
            n_fail++;
            $display("FAIL midrst_async got ce=%b oe=%h done=%b rdy=%b done_b=%b exp ce=1 oe=0 done=0 rdy=0 done_b=0",
                     a_ce, a_sio_oe, a_init_done, a_req_ready, b_init_done);
        end
        repeat (2) @(negedge clk);
        test_quiet_after_reset();
        test_init();
    endtask

    initial begin
        test_reset();
        test_quiet_after_reset();
        test_init();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
